// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the ping-pong frame buffer: write
//                FSM state encoding and frame-geometry helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Write-side FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a start-of-frame pixel
    ST_FILL = 2'd1,  // writing pixels of the current frame
    ST_DONE = 2'd2   // frame complete, waiting for the reader to take it
  } wr_state_t;

  // Number of pixels in one frame
  function automatic int calc_pixels(input int width, input int height);
    return width * height;
  endfunction

  // Pixel index width; never narrower than one bit
  function automatic int calc_addr_w(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : fb_dpram
//  Description : Simple dual-port RAM holding two frame banks. The bank bit
//                is the address MSB; the low bits index a pixel inside the
//                bank. One write port, one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_dpram #(
  parameter int DATA_W     = 8,
  parameter int HALF_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 * HALF_DEPTH;
  localparam int IW    = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [IW-1:0]     w_widx;
  logic [IW-1:0]     w_ridx;

  // Bank 1 starts right after bank 0, so non power-of-two frames stay packed
  assign w_widx = waddr[ADDR_W-1] ? IW'(HALF_DEPTH) + IW'(waddr[ADDR_W-2:0])
                                  : IW'(waddr[ADDR_W-2:0]);
  assign w_ridx = raddr[ADDR_W-1] ? IW'(HALF_DEPTH) + IW'(raddr[ADDR_W-2:0])
                                  : IW'(raddr[ADDR_W-2:0]);

  // Write port
  always_ff @(posedge clk) begin
    if (we) r_mem[w_widx] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) r_q <= r_mem[w_ridx];
  end

  assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/pingpong_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_frame_buffer
//  Description : Double-buffered frame store. A writer streams frames into
//                the write bank; on reader request a completed frame is
//                handed over by swapping banks. Reads have 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pingpong_frame_buffer
  import fb_pkg::*;
#(
  parameter  int WIDTH     = 640,
  parameter  int HEIGHT    = 480,
  parameter  int BIT_WIDTH = 8,
  localparam int PIXELS    = calc_pixels(WIDTH, HEIGHT),
  localparam int ADDR_W    = calc_addr_w(PIXELS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_sof,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BIT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_frame_req,
  output logic                 rd_frame_ack,
  output logic                 rd_frame_valid,
  output logic                 wr_resync
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);

  wr_state_t             r_state;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic                  r_wr_bank;
  logic                  r_req_pending;
  logic                  r_frame_ack;
  logic                  r_frame_valid;
  logic                  r_resync;
  logic                  r_rd_valid;
  logic                  r_rd_oob;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_we;
  logic                  w_swap;
  logic                  w_rd_inrange;
  logic [ADDR_W-1:0]     w_waddr;
  logic [BIT_WIDTH-1:0]  w_ram_q;

  // Writer is held off only while a finished frame waits for the reader
  assign w_ready  = rst_n & (r_state != ST_DONE);
  assign w_accept = wr_valid & w_ready;

  // In IDLE only a start-of-frame pixel is stored; in FILL every pixel is
  assign w_we    = w_accept & (wr_sof | (r_state == ST_FILL));
  assign w_waddr = wr_sof ? '0 : r_wr_addr;

  // Hand-over happens as soon as a finished frame meets a request
  assign w_swap = (r_state == ST_DONE) & (rd_frame_req | r_req_pending);

  assign w_rd_inrange = int'(rd_addr) < PIXELS;

  // Write FSM, bank ownership and frame hand-over handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_addr     <= '0;
      r_wr_bank     <= 1'b0;
      r_req_pending <= 1'b0;
      r_frame_ack   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_resync      <= 1'b0;
    end else begin
      r_frame_ack <= 1'b0;
      r_resync    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && wr_sof) begin
            r_wr_addr <= c_one;
            r_state   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (wr_sof) begin
              // Restart the frame in place; the partial frame is overwritten
              r_wr_addr <= c_one;
              r_resync  <= 1'b1;
            end else if (r_wr_addr == c_last_addr) begin
              r_wr_addr <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_wr_addr <= r_wr_addr + c_one;
            end
          end
        end
        ST_DONE: begin
          if (w_swap) begin
            r_wr_bank     <= ~r_wr_bank;
            r_state       <= ST_IDLE;
            r_frame_ack   <= 1'b1;
            r_frame_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_swap)            r_req_pending <= 1'b0;
      else if (rd_frame_req) r_req_pending <= 1'b1;
    end
  end

  // Read-side qualifiers aligned with the registered RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_oob   <= rd_en & ~w_rd_inrange;
    end
  end

  // Read bank is sampled with rd_en, so a same-cycle swap affects later reads
  fb_dpram #(
    .DATA_W     (BIT_WIDTH),
    .HALF_DEPTH (PIXELS),
    .ADDR_W     (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr ({r_wr_bank, w_waddr}),
    .wdata (wr_data),
    .re    (rd_en & w_rd_inrange),
    .raddr ({~r_wr_bank, rd_addr}),
    .rdata (w_ram_q)
  );

  assign wr_ready       = w_ready;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = (r_rd_valid && !r_rd_oob) ? w_ram_q : '0;
  assign rd_frame_ack   = r_frame_ack;
  assign rd_frame_valid = r_frame_valid;
  assign wr_resync      = r_resync;

endmodule
`default_nettype wire
